// File: rtl/comma_aligner.sv
// Serial-to-parallel K28.5 comma aligner with HUNT/VERIFY/LOCKED symbol-boundary tracking.
// Optional realignment statistics counter enabled by defining COMMA_ALIGN_STATS_EN.
module comma_aligner #(
    parameter int LOCK_COMMAS = 3,
    parameter int LOSS_COMMAS = 2,
    parameter int CNT_W       = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       din,
    output logic [9:0] sym_out,
    output logic       sym_valid,
    output logic       comma_det,
    output logic       locked
`ifdef COMMA_ALIGN_STATS_EN
    ,
    output logic [7:0] realign_cnt
`endif
);

    typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} state_t;

    localparam logic [9:0]       COMMA_NEG = 10'b0011111010;
    localparam logic [9:0]       COMMA_POS = 10'b1100000101;
    localparam logic [CNT_W-1:0] LOCK_C    = CNT_W'(LOCK_COMMAS);
    localparam logic [CNT_W-1:0] LOSS_C    = CNT_W'(LOSS_COMMAS);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    state_t           state_q, state_d;
    logic [9:0]       sr_q;
    logic [3:0]       bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0] vcnt_q, vcnt_d, vcnt_inc;
    logic [CNT_W-1:0] lcnt_q, lcnt_d, lcnt_inc;
    logic [9:0]       sym_out_q;
    logic             sym_valid_q, comma_det_q, locked_q;
    logic [9:0]       nxt;
    logic             is_comma, boundary, emit, realign;

    always_comb begin
        nxt       = {sr_q[8:0], din};
        is_comma  = (nxt == COMMA_NEG) || (nxt == COMMA_POS);
        boundary  = (bit_cnt_q == 4'd9);
        vcnt_inc  = (vcnt_q == '1) ? vcnt_q : vcnt_q + CNT_ONE;
        lcnt_inc  = (lcnt_q == '1) ? lcnt_q : lcnt_q + CNT_ONE;
        state_d   = state_q;
        vcnt_d    = vcnt_q;
        lcnt_d    = lcnt_q;
        bit_cnt_d = boundary ? 4'd0 : bit_cnt_q + 4'd1;
        emit      = 1'b0;
        realign   = 1'b0;

        case (state_q)
            HUNT: begin
                if (is_comma) begin
                    realign = 1'b1;
                    state_d = (LOCK_COMMAS == 1) ? LOCKED : VERIFY;
                end
            end
            VERIFY: begin
                if (boundary) begin
                    emit = 1'b1;
                    if (is_comma) begin
                        vcnt_d = vcnt_inc;
                        if (vcnt_inc == LOCK_C) begin
                            state_d = LOCKED;
                            lcnt_d  = '0;
                        end
                    end
                end else if (is_comma) begin
                    realign = 1'b1;
                end
            end
            LOCKED: begin
                if (boundary) begin
                    emit = 1'b1;
                    if (is_comma) lcnt_d = '0;
                end else if (is_comma) begin
                    // A stray comma while locked is tolerated until LOSS_COMMAS accumulate.
                    if (lcnt_inc == LOSS_C) begin
                        realign = 1'b1;
                        state_d = (LOCK_COMMAS == 1) ? LOCKED : VERIFY;
                    end else begin
                        lcnt_d = lcnt_inc;
                    end
                end
            end
            default: state_d = HUNT;
        endcase

        if (realign) begin
            emit      = 1'b1;
            bit_cnt_d = 4'd0;
            vcnt_d    = CNT_ONE;
            lcnt_d    = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= HUNT;
            sr_q        <= '0;
            bit_cnt_q   <= '0;
            vcnt_q      <= '0;
            lcnt_q      <= '0;
            sym_out_q   <= '0;
            sym_valid_q <= 1'b0;
            comma_det_q <= 1'b0;
            locked_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            sr_q        <= nxt;
            bit_cnt_q   <= bit_cnt_d;
            vcnt_q      <= vcnt_d;
            lcnt_q      <= lcnt_d;
            sym_valid_q <= emit;
            locked_q    <= (state_d == LOCKED);
            if (emit) begin
                sym_out_q   <= nxt;
                comma_det_q <= is_comma;
            end
        end
    end

    assign sym_out   = sym_out_q;
    assign sym_valid = sym_valid_q;
    assign comma_det = comma_det_q;
    assign locked    = locked_q;

`ifdef COMMA_ALIGN_STATS_EN
    logic [7:0] realign_cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            realign_cnt_q <= '0;
        end else if (realign && (realign_cnt_q != 8'hFF)) begin
            realign_cnt_q <= realign_cnt_q + 8'd1;
        end
    end

    assign realign_cnt = realign_cnt_q;
`endif

endmodule

// File: tb/tb_comma_aligner.sv
// Directed bench for comma_aligner: reset, lock, verify restart, loss, lcnt clear, mid-symbol reset,
// and the realignment counter when COMMA_ALIGN_STATS_EN is defined.
module tb_comma_aligner;

    logic       clk;
    logic       rst;
    logic       din;
    logic [9:0] sym_out;
    logic       sym_valid;
    logic       comma_det;
    logic       locked;
`ifdef COMMA_ALIGN_STATS_EN
    logic [7:0] realign_cnt;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    // Expected emitted symbols: {comma_det, sym_out}
    logic [10:0] exp_q[$];

    comma_aligner dut (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .sym_out   (sym_out),
        .sym_valid (sym_valid),
        .comma_det (comma_det),
        .locked    (locked)
`ifdef COMMA_ALIGN_STATS_EN
        ,
        .realign_cnt (realign_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    // Send n bits MSB first; after each edge sym_valid must equal the matching vmask bit,
    // and every expected pulse pops one {comma_det, sym_out} entry from exp_q.
    task automatic send_bits(input string tag, input logic [31:0] bits, input int n,
                             input logic [31:0] vmask);
        logic [10:0] e;
        for (int i = n - 1; i >= 0; i--) begin
            din = bits[i];
            @(posedge clk);
            #1;
            chk($sformatf("%s_valid_b%0d", tag, i), 32'(sym_valid), 32'(vmask[i]));
            if (vmask[i]) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 11'h7FF;
                chk($sformatf("%s_sym_b%0d", tag, i), 32'(sym_out), 32'(e[9:0]));
                chk($sformatf("%s_comma_b%0d", tag, i), 32'(comma_det), 32'(e[10]));
            end
        end
    endtask

`ifdef COMMA_ALIGN_STATS_EN
    task automatic send_raw(input logic [31:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            din = bits[i];
            @(posedge clk);
            #1;
        end
    endtask
`endif

    initial begin
        rst = 1'b0;
        din = 1'b0;

        // T1: reset with random line activity, then 40 non-comma bits
        for (int i = 0; i < 5; i++) begin
            din = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
        end
        chk("rst_sym_out", 32'(sym_out), 32'h0);
        chk("rst_sym_valid", 32'(sym_valid), 32'h0);
        chk("rst_comma_det", 32'(comma_det), 32'h0);
        chk("rst_locked", 32'(locked), 32'h0);
`ifdef COMMA_ALIGN_STATS_EN
        chk("rst_realign_cnt", 32'(realign_cnt), 32'h0);
`endif
        rst = 1'b1;
        for (int k = 0; k < 4; k++) send_bits("t1_idle", 32'h2AA, 10, 32'h0);
        chk("t1_locked", 32'(locked), 32'h0);

        // T2: three random bits, then K28.5-, D21.5, K28.5+, K28.5-
        send_bits("t2_pre", 32'($urandom_range(0, 7)), 3, 32'h0);
        exp_q.push_back({1'b1, 10'h0FA});
        send_bits("t2_c1", 32'h0FA, 10, 32'h1);
        chk("t2_locked_c1", 32'(locked), 32'h0);
        exp_q.push_back({1'b0, 10'h2AA});
        send_bits("t2_d", 32'h2AA, 10, 32'h1);
        chk("t2_locked_d", 32'(locked), 32'h0);
        exp_q.push_back({1'b1, 10'h305});
        send_bits("t2_c2", 32'h305, 10, 32'h1);
        chk("t2_locked_c2", 32'(locked), 32'h0);
        exp_q.push_back({1'b1, 10'h0FA});
        send_bits("t2_c3", 32'h0FA, 10, 32'h1);
        chk("t2_locked_c3", 32'(locked), 32'h1);

        // T5: misaligned comma, aligned comma, misaligned comma while locked
        exp_q.push_back({1'b0, 10'h147});
        exp_q.push_back({1'b0, 10'h355});
        send_bits("t5_mis1", 32'b01010_0011111010_10101, 20, 32'h401);
        chk("t5_locked_mis1", 32'(locked), 32'h1);
        exp_q.push_back({1'b1, 10'h0FA});
        send_bits("t5_al", 32'h0FA, 10, 32'h1);
        chk("t5_locked_al", 32'(locked), 32'h1);
        exp_q.push_back({1'b0, 10'h147});
        exp_q.push_back({1'b0, 10'h355});
        send_bits("t5_mis2", 32'b01010_0011111010_10101, 20, 32'h401);
        chk("t5_locked_mis2", 32'(locked), 32'h1);
        exp_q.push_back({1'b1, 10'h0FA});
        send_bits("t5_clr", 32'h0FA, 10, 32'h1);

        // T4: slip by three bits, then two commas
        exp_q.push_back({1'b0, 10'h29F});
        send_bits("t4_s1", 32'b101_0011111010, 13, 32'h8);
        chk("t4_locked_s1", 32'(locked), 32'h1);
        exp_q.push_back({1'b0, 10'h11F});
        exp_q.push_back({1'b1, 10'h0FA});
        send_bits("t4_s2", 32'h0FA, 10, 32'h9);
        chk("t4_locked_s2", 32'(locked), 32'h0);

        // T3: one aligned comma in VERIFY, then a 4-bit slip forces a restart
        exp_q.push_back({1'b1, 10'h305});
        send_bits("t3_al", 32'h305, 10, 32'h1);
        chk("t3_locked_al", 32'(locked), 32'h0);
        exp_q.push_back({1'b0, 10'h14F});
        exp_q.push_back({1'b1, 10'h0FA});
        send_bits("t3_slip", 32'b0101_0011111010, 14, 32'h11);
        chk("t3_locked_slip", 32'(locked), 32'h0);
        exp_q.push_back({1'b0, 10'h2AA});
        send_bits("t3_d", 32'h2AA, 10, 32'h1);
        chk("t3_locked_d", 32'(locked), 32'h0);
        exp_q.push_back({1'b1, 10'h0FA});
        send_bits("t3_c2", 32'h0FA, 10, 32'h1);
        chk("t3_locked_c2", 32'(locked), 32'h0);
        exp_q.push_back({1'b1, 10'h305});
        send_bits("t3_c3", 32'h305, 10, 32'h1);
        chk("t3_locked_c3", 32'(locked), 32'h1);

        // Reset mid-symbol: the first half of a comma must not survive reset
        send_bits("mr_half", 32'b00111, 5, 32'h0);
        rst = 1'b0;
        #1;
        chk("mr_sym_out", 32'(sym_out), 32'h0);
        chk("mr_locked", 32'(locked), 32'h0);
        chk("mr_sym_valid", 32'(sym_valid), 32'h0);
        chk("mr_comma_det", 32'(comma_det), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        send_bits("mr_tail", 32'b11010, 5, 32'h0);
        exp_q.push_back({1'b1, 10'h0FA});
        send_bits("mr_fresh", 32'h0FA, 10, 32'h1);
        chk("mr_locked_fresh", 32'(locked), 32'h0);

`ifdef COMMA_ALIGN_STATS_EN
        // T6: saturating realignment counter and async clear
        chk("t6_cnt_one", 32'(realign_cnt), 32'h1);
        for (int k = 0; k < 300; k++) send_raw({21'h0, 1'b0, 10'h0FA}, 11);
        chk("t6_cnt_sat", 32'(realign_cnt), 32'hFF);
        chk("t6_valid_pre", 32'(sym_valid), 32'h1);
        rst = 1'b0;
        #1;
        chk("t6_cnt_rst", 32'(realign_cnt), 32'h0);
        chk("t6_valid_rst", 32'(sym_valid), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b1;
`endif

        chk("exp_q_drained", 32'(exp_q.size()), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
